// File: rtl/binary_to_excess_pkg.sv
// Shared constants and types for the binary/excess-K code converter.
package binary_to_excess_pkg;

   localparam int DEF_WIDTH  = 4;
   localparam int DEF_EXCESS = 3;
   localparam int BCD_MAX    = 9;

   typedef enum logic {
      DIR_ENCODE = 1'b0,
      DIR_DECODE = 1'b1
   } dir_e;

endpackage

// File: rtl/binary_to_excess_addsub.sv
// Combinational add/subtract-constant unit: a ripple chain of full-adder cells
// computing b + K (dir=0) or b - K (dir=1), with the carry/borrow as the MSB.
module excess_addsub
   import binary_to_excess_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int EXCESS = DEF_EXCESS
) (
   input  logic             dir,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   res
);

   localparam logic [WIDTH-1:0] K = WIDTH'(EXCESS);

   logic [WIDTH-1:0] k_op;
   logic [WIDTH-1:0] sum;
   logic [WIDTH:0]   carry;

   // Subtraction is b + ~K + 1, so the constant is inverted and dir is the carry-in.
   assign k_op     = K ^ {WIDTH{dir}};
   assign carry[0] = dir;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign sum[i]       = b[i] ^ k_op[i] ^ carry[i];
      assign carry[i+1]   = (b[i] & k_op[i]) | (carry[i] & (b[i] ^ k_op[i]));
   end

   // A missing carry-out on subtraction is a borrow.
   assign res = {carry[WIDTH] ^ dir, sum};

endmodule

// File: rtl/binary_to_excess.sv
// Registered binary <-> excess-K converter with modulo-wrap flag.
// Define BINARY_TO_EXCESS_BCD_CHECK_EN to build the BCD range checker driving bcd_err.
module binary_to_excess
   import binary_to_excess_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int EXCESS = DEF_EXCESS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             dir,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] x,
   output logic             wrap,
   output logic             bcd_err
);

   dir_e             dir_p0;
   logic [WIDTH:0]   res_p0;
   logic             vld_p1;
   logic [WIDTH-1:0] x_p1;
   logic             wrap_p1;

   assign dir_p0 = dir_e'(dir);

   excess_addsub #(
      .WIDTH  (WIDTH),
      .EXCESS (EXCESS)
   ) u_addsub (
      .dir (dir),
      .b   (b),
      .res (res_p0)
   );

   // Stage p0 -> p1: capture result; data holds while no input is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         x_p1    <= '0;
         wrap_p1 <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            x_p1    <= res_p0[WIDTH-1:0];
            wrap_p1 <= res_p0[WIDTH];
         end
      end
   end

`ifdef BINARY_TO_EXCESS_BCD_CHECK_EN
   logic [31:0] b_ext_p0;
   logic        bcd_err_p0;
   logic        bcd_err_p1;

   assign b_ext_p0 = 32'(b);

   always_comb begin
      bcd_err_p0 = 1'b0;
      if (dir_p0 == DIR_ENCODE) begin
         bcd_err_p0 = b_ext_p0 > 32'(BCD_MAX);
      end else begin
         bcd_err_p0 = (b_ext_p0 < 32'(EXCESS)) || (b_ext_p0 > 32'(BCD_MAX + EXCESS));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bcd_err_p1 <= 1'b0;
      end else if (in_valid) begin
         bcd_err_p1 <= bcd_err_p0;
      end
   end

   assign bcd_err = bcd_err_p1;
`else
   dir_e unused_dir_p0;
   assign unused_dir_p0 = dir_p0;
   assign bcd_err       = 1'b0;
`endif

   assign out_valid = vld_p1;
   assign x         = x_p1;
   assign wrap      = wrap_p1;

endmodule

// File: tb/tb_binary_to_excess.sv
// Scoreboard bench for binary_to_excess: reference model pushes expectations
// on each accepted input, a negedge monitor pops and compares.
module tb_binary_to_excess;

   localparam int W = 4;
   localparam int K = 3;
   localparam int M = 1 << W;

   typedef struct {
      int x;
      int wrap;
      int bcd;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         dir = 1'b0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic [W-1:0] x;
   logic         wrap;
   logic         bcd_err;

   int n_checks = 0;
   int n_fail   = 0;
   exp_t exp_q[$];
   int   last_x = 0, last_wrap = 0, last_bcd = 0;
   logic rst_q = 1'b1;
   logic done = 1'b0;

   always #5 clk = ~clk;

   binary_to_excess #(.WIDTH(W), .EXCESS(K)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .dir       (dir),
      .b         (b),
      .out_valid (out_valid),
      .x         (x),
      .wrap      (wrap),
      .bcd_err   (bcd_err)
   );

   function automatic exp_t model(input int bv, input int d);
      exp_t e;
      if (d == 0) begin
         e.x    = (bv + K) % M;
         e.wrap = (bv + K >= M) ? 1 : 0;
      end else begin
         e.x    = (bv - K + M) % M;
         e.wrap = (bv < K) ? 1 : 0;
      end
`ifdef BINARY_TO_EXCESS_BCD_CHECK_EN
      if (d == 0) e.bcd = (bv > 9) ? 1 : 0;
      else        e.bcd = (bv < K || bv > 9 + K) ? 1 : 0;
`else
      e.bcd = 0;
`endif
      return e;
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Scoreboard input side: record what the DUT accepts at each edge.
   always @(posedge clk) begin
      rst_q = rst;
      if (rst) exp_q.delete();
      else if (in_valid) exp_q.push_back(model(int'(b), int'(dir)));
   end

   // Monitor: sample mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (!done) begin
         if (rst_q) begin
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_x", int'(x), 0);
            check("rst_wrap", int'(wrap), 0);
            check("rst_bcd_err", int'(bcd_err), 0);
            last_x = 0; last_wrap = 0; last_bcd = 0;
         end else begin
            check("out_valid", int'(out_valid), (exp_q.size() != 0) ? 1 : 0);
            if (exp_q.size() != 0) begin
               exp_t e;
               e = exp_q.pop_front();
               check("x", int'(x), e.x);
               check("wrap", int'(wrap), e.wrap);
               check("bcd_err", int'(bcd_err), e.bcd);
               last_x = e.x; last_wrap = e.wrap; last_bcd = e.bcd;
            end else begin
               check("hold_x", int'(x), last_x);
               check("hold_wrap", int'(wrap), last_wrap);
               check("hold_bcd_err", int'(bcd_err), last_bcd);
            end
         end
      end
   end

   task automatic drive(input logic r, input logic v, input logic d, input int bv);
      @(posedge clk);
      #1;
      rst      = r;
      in_valid = v;
      dir      = d;
      b        = W'(bv);
   endtask

   initial begin
      // Reset with a live input that must be discarded.
      drive(1, 1, 0, 5);
      drive(1, 1, 0, 5);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);

      for (int i = 0; i < M; i++) drive(0, 1, 0, i);
      drive(0, 1, 1, 3);
      drive(0, 1, 1, 12);
      drive(0, 1, 1, 2);

      drive(0, 1, 0, 7);
      for (int i = 0; i < 5; i++) drive(0, 0, $urandom_range(0, 1), $urandom_range(0, M - 1));

      drive(0, 1, 0, 9);
      drive(0, 1, 0, 10);
      drive(0, 1, 1, 13);
      drive(0, 1, 1, 0);

      // Mid-stream reset.
      drive(0, 1, 0, 12);
      drive(1, 1, 1, 4);
      drive(0, 1, 1, 15);
      drive(0, 0, 0, 0);

      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
               $urandom_range(0, 1), $urandom_range(0, M - 1));
      end
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      @(negedge clk);
      #1;
      done = 1'b1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
